// File: rtl/div_pkg.sv
// Shared configuration, latency helper and stage payload for the pipelined divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_TAG_W = 8;

    // Pipeline depth in registers: P0 + one per quotient bit + PF/output register.
    function automatic int unsigned div_lat(input int unsigned width);
        return width + 2;
    endfunction

    localparam int unsigned DIV_LAT = div_lat(DIV_WIDTH);

    // Legal parameter range for the divider.
    function automatic bit div_params_ok(input int unsigned width, input int unsigned tag_w);
        return (width >= 4) && (tag_w >= 1);
    endfunction

    // Payload travelling down the restoring stages.
    typedef struct packed {
        logic [DIV_WIDTH:0]   rem;    // partial remainder, one guard bit
        logic [DIV_WIDTH-1:0] quo;    // dividend bits shifting out, quotient bits shifting in
        logic [DIV_WIDTH-1:0] dvs;    // divisor magnitude
        logic                 neg_q;
        logic                 neg_r;
        logic                 div0;
        logic [DIV_WIDTH-1:0] raw_a;  // original dividend, returned on divide-by-zero
        logic [DIV_TAG_W-1:0] tag;
    } div_stage_t;

endpackage

// File: rtl/div_stage.sv
// One restoring division step followed by its pipeline register; holds when adv_i is low.
module div_stage
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv_i,
    input  logic       vld_i,
    input  div_stage_t pl_i,
    output logic       vld_o,
    output div_stage_t pl_o
);

    localparam int unsigned W = DIV_WIDTH;

    logic [W+1:0] shifted;
    logic [W:0]   diff;
    logic         qbit;
    div_stage_t   pl_d;
    logic         vld_q;
    div_stage_t   pl_q;

    // Trial subtract of the divisor from {rem, next dividend bit}; keep difference when non-negative.
    always_comb begin
        shifted  = {pl_i.rem, pl_i.quo[W-1]};
        qbit     = (shifted >= {2'b00, pl_i.dvs});
        diff     = shifted[W:0] - {1'b0, pl_i.dvs};
        pl_d     = pl_i;
        pl_d.rem = qbit ? diff : shifted[W:0];
        pl_d.quo = {pl_i.quo[W-2:0], qbit};
    end

    // Stage register; every field freezes while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            pl_q  <= '0;
        end else if (adv_i) begin
            vld_q <= vld_i;
            pl_q  <= pl_d;
        end
    end

    assign vld_o = vld_q;
    assign pl_o  = pl_q;

endmodule

// File: rtl/div_pipe_hs.sv
// Fully pipelined restoring integer divider with valid/ready handshake, signed mode and tag.
module div_pipe_hs
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned TAG_W = DIV_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div0,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned NSTG = div_lat(WIDTH);

    if (!div_params_ok(WIDTH, TAG_W) || (WIDTH != DIV_WIDTH) || (TAG_W != DIV_TAG_W)) begin : g_param_chk
        $error("div_pipe_hs: WIDTH/TAG_W must match div_pkg and satisfy WIDTH >= 4, TAG_W >= 1");
    end

    logic             adv;
    logic             sa;
    logic             sb;
    div_stage_t       p0_d;
    logic             p0_vld_q;
    div_stage_t       p0_q;
    logic [WIDTH-1:0] s_vld;
    div_stage_t       s_pl [WIDTH];
    logic [WIDTH-1:0] pf_quo;
    logic [WIDTH-1:0] pf_rem;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_quotient_q;
    logic [WIDTH-1:0] out_remainder_q;
    logic             out_div0_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [NSTG-1:0]  vld_all;

    // Whole pipeline moves together whenever the output register is free or being drained.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // P0: take operand magnitudes in signed mode and record result signs and divide-by-zero.
    always_comb begin
        sa         = in_signed & in_a[WIDTH-1];
        sb         = in_signed & in_b[WIDTH-1];
        p0_d       = '0;
        p0_d.quo   = sa ? WIDTH'(-in_a) : in_a;
        p0_d.dvs   = sb ? WIDTH'(-in_b) : in_b;
        p0_d.neg_q = sa ^ sb;
        p0_d.neg_r = sa;
        p0_d.div0  = (in_b == '0);
        p0_d.raw_a = in_a;
        p0_d.tag   = in_tag;
    end

    // P0 register; a transfer is simply in_valid on an advancing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_vld_q <= 1'b0;
            p0_q     <= '0;
        end else if (adv) begin
            p0_vld_q <= in_valid;
            p0_q     <= p0_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            div_stage u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .adv_i (adv),
                .vld_i (p0_vld_q),
                .pl_i  (p0_q),
                .vld_o (s_vld[i]),
                .pl_o  (s_pl[i])
            );
        end else begin : g_rest
            div_stage u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .adv_i (adv),
                .vld_i (s_vld[i-1]),
                .pl_i  (s_pl[i-1]),
                .vld_o (s_vld[i]),
                .pl_o  (s_pl[i])
            );
        end
    end

    // PF: restore signs, or force the divide-by-zero result.
    always_comb begin
        pf_quo = s_pl[WIDTH-1].quo;
        pf_rem = s_pl[WIDTH-1].rem[WIDTH-1:0];
        if (s_pl[WIDTH-1].div0) begin
            pf_quo = '1;
            pf_rem = s_pl[WIDTH-1].raw_a;
        end else begin
            if (s_pl[WIDTH-1].neg_q) begin
                pf_quo = WIDTH'(-s_pl[WIDTH-1].quo);
            end
            if (s_pl[WIDTH-1].neg_r) begin
                pf_rem = WIDTH'(-s_pl[WIDTH-1].rem[WIDTH-1:0]);
            end
        end
    end

    // Output register; data only changes when a new result moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            out_div0_q      <= 1'b0;
            out_tag_q       <= '0;
        end else if (adv) begin
            out_valid_q <= s_vld[WIDTH-1];
            if (s_vld[WIDTH-1]) begin
                out_quotient_q  <= pf_quo;
                out_remainder_q <= pf_rem;
                out_div0_q      <= s_pl[WIDTH-1].div0;
                out_tag_q       <= s_pl[WIDTH-1].tag;
            end
        end
    end

    assign vld_all       = {out_valid_q, s_vld, p0_vld_q};
    assign busy          = |vld_all;
    assign out_valid     = out_valid_q;
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign out_div0      = out_div0_q;
    assign out_tag       = out_tag_q;

endmodule

// File: tb/tb_div_pipe_hs.sv
// Randomised scoreboard bench for div_pipe_hs with an arithmetic reference model.
module tb_div_pipe_hs;
    import div_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        d0;
        logic [7:0]  tag;
        int          acc;
        int          st;
    } op_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic        out_div0;
    logic [7:0]  out_tag;
    logic        busy;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  stalls   = 0;
    bit  rand_ready = 0;
    op_t sb[$];

    bit          prev_hold = 0;
    logic [31:0] h_q;
    logic [31:0] h_r;
    logic        h_d0;
    logic [7:0]  h_tag;

    div_pipe_hs #(.WIDTH(32), .TAG_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_signed     (in_signed),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_div0      (out_div0),
        .out_tag       (out_tag),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division from the arithmetic definition of each mode.
    function automatic op_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input logic [7:0] t);
        op_t    m;
        longint sa;
        longint sbv;
        longint qq;
        longint rr;
        m.tag = t;
        m.acc = 0;
        m.st  = 0;
        if (b == 32'd0) begin
            m.q  = 32'hFFFF_FFFF;
            m.r  = a;
            m.d0 = 1'b1;
        end else if (!s) begin
            m.q  = a / b;
            m.r  = a % b;
            m.d0 = 1'b0;
        end else begin
            sa   = longint'($signed(a));
            sbv  = longint'($signed(b));
            qq   = sa / sbv;
            rr   = sa % sbv;
            m.q  = qq[31:0];
            m.r  = rr[31:0];
            m.d0 = 1'b0;
        end
        return m;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: order, values, latency (DIV_LAT plus stalls in flight) and stall stability.
    always @(negedge clk) begin
        op_t e;
        op_t m;
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            cyc++;
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_quotient", out_quotient, h_q);
                chk("hold_remainder", out_remainder, h_r);
                chk("hold_div0", 32'(out_div0), 32'(h_d0));
                chk("hold_tag", 32'(out_tag), 32'(h_tag));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", out_quotient, e.q);
                    chk("remainder", out_remainder, e.r);
                    chk("div0", 32'(out_div0), 32'(e.d0));
                    chk("tag", 32'(out_tag), 32'(e.tag));
                    chk("latency", 32'(cyc - e.acc), 32'(int'(DIV_LAT) + (stalls - e.st)));
                end
            end
            if (out_valid && !out_ready) stalls++;
            prev_hold = out_valid && !out_ready;
            h_q   = out_quotient;
            h_r   = out_remainder;
            h_d0  = out_div0;
            h_tag = out_tag;
            if (in_valid && in_ready) begin
                m     = model(in_a, in_b, in_signed, in_tag);
                m.acc = cyc;
                m.st  = stalls;
                sb.push_back(m);
            end
        end
    end

    // Present one operation and hold it until accepted; entered and left at posedge+1.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [7:0] t);
        int n;
        bit acc;
        n         = 0;
        acc       = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = t;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 32'(sb.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        op_t         m;
        int          n;
        int          sel;
        logic [31:0] a;
        logic [31:0] b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;

        // Model pinned to hand-computed results.
        m = model(32'd100, 32'd7, 1'b0, 8'h5A);
        chk("pin_u_q", m.q, 32'd14);
        chk("pin_u_r", m.r, 32'd2);
        m = model(32'hFFFF_FFF9, 32'd2, 1'b1, 8'h01);
        chk("pin_s1_q", m.q, 32'hFFFF_FFFD);
        chk("pin_s1_r", m.r, 32'hFFFF_FFFF);
        m = model(32'd7, 32'hFFFF_FFFE, 1'b1, 8'h02);
        chk("pin_s2_q", m.q, 32'hFFFF_FFFD);
        chk("pin_s2_r", m.r, 32'd1);
        m = model(32'h1234, 32'd0, 1'b0, 8'h03);
        chk("pin_u0_q", m.q, 32'hFFFF_FFFF);
        chk("pin_u0_r", m.r, 32'h1234);
        chk("pin_u0_d", 32'(m.d0), 32'd1);
        m = model(32'hFFFF_FFFB, 32'd0, 1'b1, 8'h04);
        chk("pin_s0_r", m.r, 32'hFFFF_FFFB);
        m = model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 8'h05);
        chk("pin_ovf_q", m.q, 32'h8000_0000);
        chk("pin_ovf_r", m.r, 32'd0);
        chk("pin_ovf_d", 32'(m.d0), 32'd0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", out_quotient, 32'd0);
        chk("rst_remainder", out_remainder, 32'd0);
        chk("rst_div0", 32'(out_div0), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First directed op, checked against literals straight off the ports.
        send(32'd100, 32'd7, 1'b0, 8'h5A);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dir_seen", 32'(out_valid), 32'd1);
        chk("dir_quotient", out_quotient, 32'd14);
        chk("dir_remainder", out_remainder, 32'd2);
        chk("dir_tag", 32'(out_tag), 32'h5A);
        chk("dir_div0", 32'(out_div0), 32'd0);
        @(posedge clk);
        #1;

        // Remaining directed corners, back to back.
        send(32'hFFFF_FFF9, 32'd2, 1'b1, 8'h11);
        send(32'd7, 32'hFFFF_FFFE, 1'b1, 8'h12);
        send(32'h1234, 32'd0, 1'b0, 8'h13);
        send(32'hFFFF_FFFB, 32'd0, 1'b1, 8'h14);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 8'h15);
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 8'h16);
        drain();

        // Random stream under random backpressure.
        rand_ready = 1;
        for (int i = 0; i < 1000; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3, 4, 5: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = 32'h8000_0000;
            else if (sel < 3)  a = 32'($urandom_range(0, 255));
            else               a = $urandom;
            send(a, b, 1'($urandom_range(0, 1)), 8'(i));
        end
        rand_ready = 0;
        drain();

        // Reset with operations in flight.
        for (int i = 0; i < 10; i++) begin
            send($urandom, 32'($urandom_range(1, 1000)), 1'($urandom_range(0, 1)), 8'(8'hC0 + i));
        end
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        send(32'd1000, 32'd33, 1'b0, 8'hEE);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
